bcd_cnt_disp: RTL and testbench
===============================

BCD_CNT_DISP -- requirements
Module: bcd_cnt_disp

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of BCD digits (legal range 1..8).
REQ-002 SHALL have parameter CE_DIV, default 1, count of CE_SCAN ticks per digit-scan step (legal range 1..255).
REQ-003 SHALL have port CLK, input, 1 bit, system clock.
REQ-004 SHALL have port RST, input, 1 bit, reset: asynchronous, active-high.
REQ-005 SHALL have port CE_SCAN, input, 1 bit, one-cycle scan-rate clock enable.
REQ-006 SHALL have port BTN_INC, input, 1 bit, one-cycle debounced increment pulse from the button filter.
REQ-007 SHALL have port BTN_DEC, input, 1 bit, one-cycle debounced decrement pulse.
REQ-008 SHALL have port BTN_CLR, input, 1 bit, one-cycle debounced clear pulse.
REQ-009 SHALL have port SEG, output, 7 bits, segments g..a, active-low, registered.
REQ-010 SHALL have port AN, output, NDIG bits, digit anodes, one-hot active-low, registered.
REQ-011 SHALL have port OVF, output, 1 bit, one-cycle wrap pulse, registered.
REQ-012 SHALL have port VALUE, output, 4*NDIG bits, packed BCD count, digit 0 in bits [3:0].

Function
REQ-013 SHALL hold an NDIG-digit BCD count, range 0..10^NDIG-1, every nibble always 0..9.
REQ-014 SHALL apply count updates on the CLK edge where the pulse is high; VALUE is updated 1 cycle after the pulse.
REQ-015 SHALL give priority CLR > (INC xor DEC); CLR sets the count to 0 regardless of INC/DEC.
REQ-016 SHALL leave the count unchanged when INC and DEC are both high without CLR.
REQ-017 SHALL apply ripple carry on INC: 9 -> 0 with carry into the next digit.
REQ-018 SHALL wrap INC at all-9s to all-0s and assert OVF for exactly 1 cycle, registered with the count.
REQ-019 SHALL apply ripple borrow on DEC: 0 -> 9 with borrow into the next digit.
REQ-020 SHALL wrap DEC at all-0s to all-9s and assert OVF for exactly 1 cycle.
REQ-021 SHALL not assert OVF on CLR.
REQ-022 SHALL count CE_SCAN pulses in a prescaler modulo CE_DIV; a step occurs on the tick that takes the prescaler from CE_DIV-1 to 0.
REQ-023 SHALL advance the digit index 0..NDIG-1 on each step and wrap to 0 after NDIG-1.
REQ-024 SHALL update AN and SEG for the new index on the same CLK edge as the step (1-cycle latency from CE_SCAN).
REQ-025 SHALL decode SEG from the current count at that edge.
REQ-026 SHALL hold SEG and AN constant between steps, even if the count changes.
REQ-027 SHALL use hex 0..9 glyphs, standard active-low encoding (e.g. "0" = 7'b1000000, "8" = 7'b0000000).
REQ-028 SHALL make count logic and scan logic independent: a scan step and a button pulse in the same cycle both take effect.

Reset
REQ-029 SHALL on RST high, immediately set count = 0, OVF = 0, prescaler = 0, digit index = 0, AN = all ones (dark), SEG = 7'h7F.
REQ-030 SHALL leave the display dark after RST release until the first scan step.
REQ-031 SHALL lose any in-flight count update on RST mid-operation.
REQ-032 SHALL treat a pulse in the first cycle after RST release as normal.

Configuration
REQ-033 SHALL, with macro BCD_CNT_DISP_LZB_EN defined, blank leading zero digits: SEG = 7'h7F for every digit above the most-significant nonzero digit.
REQ-034 SHALL never blank digit 0 when BCD_CNT_DISP_LZB_EN is defined.
REQ-035 SHALL, with BCD_CNT_DISP_LZB_EN undefined, display all digits including leading zeros.
REQ-036 SHALL keep AN scanning unchanged in both BCD_CNT_DISP_LZB_EN configurations.

Structure
REQ-037 SHALL place the segment glyph constants (0..9, BLANK = 7'h7F) and the BCD digit width constant (4) in a shared package, seg_pkg.
REQ-038 SHALL implement BCD-to-segment decoding in sub-module bcd2seg (4-bit in, 7-bit out, combinational), instantiated once, fed by the muxed current digit.

Verification
REQ-039 SHALL verify: RST, 5 BTN_INC pulses -> VALUE = 16'h0005, OVF never high.
REQ-040 SHALL verify: count 16'h9999, 1 BTN_INC -> VALUE = 16'h0000, OVF high exactly 1 cycle.
REQ-041 SHALL verify: count 16'h0000, 1 BTN_DEC -> VALUE = 16'h9999, OVF 1 cycle; then BTN_INC+BTN_DEC in the same cycle -> VALUE stays 16'h9999.
REQ-042 SHALL verify: count 16'h0120, BTN_CLR+BTN_INC in the same cycle -> VALUE = 16'h0000, no OVF.
REQ-043 SHALL verify: CE_DIV = 2, 8 CE_SCAN ticks -> AN sequence 1110, 1101, 1011, 0111, one step per 2 ticks, SEG matching each digit 1 cycle after the tick.
REQ-044 SHALL verify: BCD_CNT_DISP_LZB_EN defined, count 16'h0007 -> digits 3..1 SEG = 7'h7F, digit 0 SEG = 7'b1111000; count 0 -> digit 0 shows "0".

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared BCD digit width and seven-segment glyph constants
//
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low:
// a 0 bit lights that segment.
package seg_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd2seg.sv
// rtl/bcd2seg.sv - combinational BCD digit to active-low seven-segment decoder
//
// Ports:
//   bcd_i  in   BCD_W  BCD digit 0..9
//   seg_o  out  7      segments {g..a}, active-low; codes 10..15 decode to blank
module bcd2seg
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_cnt_disp.sv
// rtl/bcd_cnt_disp.sv - NDIG-digit BCD up/down counter with multiplexed 7-segment scan
//
// Parameters:
//   NDIG     number of BCD digits (1..8)
//   CE_DIV   CE_SCAN ticks per digit-scan step (1..255)
// Ports:
//   CLK      in   1          system clock
//   RST      in   1          asynchronous active-high reset
//   CE_SCAN  in   1          one-cycle scan-rate enable
//   BTN_INC  in   1          one-cycle increment pulse
//   BTN_DEC  in   1          one-cycle decrement pulse
//   BTN_CLR  in   1          one-cycle clear pulse (wins over INC/DEC)
//   SEG      out  7          registered segments {g..a}, active-low
//   AN       out  NDIG       registered one-hot active-low digit anodes
//   OVF      out  1          registered one-cycle wrap pulse
//   VALUE    out  4*NDIG     packed BCD count, digit 0 in [3:0]
// Build option:
//   BCD_CNT_DISP_LZB_EN  blank leading zero digits (digit 0 is never blanked)
module bcd_cnt_disp
  import seg_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int CE_DIV = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE_SCAN,
  input  logic                  BTN_INC,
  input  logic                  BTN_DEC,
  input  logic                  BTN_CLR,
  output logic [6:0]            SEG,
  output logic [NDIG-1:0]       AN,
  output logic                  OVF,
  output logic [BCD_W*NDIG-1:0] VALUE
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = BCD_W * NDIG;

  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    inc_val, dec_val;
  logic             inc_carry, dec_borrow;
  logic             ovf_q, ovf_d;

  logic [7:0]       presc_q, presc_d;
  logic             step;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [BCD_W-1:0] cur_digit;
  logic [6:0]       glyph;
  logic             blank;

  // Ripple increment: each 9 rolls to 0 and passes the carry on; a carry
  // out of the top digit is the all-9s wrap.
  always_comb begin
    inc_val   = count_q;
    inc_carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (inc_carry) begin
        if (count_q[BCD_W*i +: BCD_W] == 4'd9) begin
          inc_val[BCD_W*i +: BCD_W] = 4'd0;
        end else begin
          inc_val[BCD_W*i +: BCD_W] = count_q[BCD_W*i +: BCD_W] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  // Ripple decrement: each 0 rolls to 9 and passes the borrow on.
  always_comb begin
    dec_val    = count_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (dec_borrow) begin
        if (count_q[BCD_W*i +: BCD_W] == 4'd0) begin
          dec_val[BCD_W*i +: BCD_W] = 4'd9;
        end else begin
          dec_val[BCD_W*i +: BCD_W] = count_q[BCD_W*i +: BCD_W] - 4'd1;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  // Clear dominates; INC and DEC together cancel out.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (BTN_CLR) begin
      count_d = '0;
    end else if (BTN_INC && !BTN_DEC) begin
      count_d = inc_val;
      ovf_d   = inc_carry;
    end else if (BTN_DEC && !BTN_INC) begin
      count_d = dec_val;
      ovf_d   = dec_borrow;
    end
  end

  always_comb begin
    step    = 1'b0;
    presc_d = presc_q;
    if (CE_SCAN) begin
      if (presc_q == 8'(CE_DIV - 1)) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  assign idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);

  // idx_q names the digit shown on the next step, so the first step after
  // reset lights digit 0.
  always_comb begin
    cur_digit = '0;
    blank     = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = count_q[BCD_W*i +: BCD_W];
      end
    end
`ifdef BCD_CNT_DISP_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    for (int i = 1; i < NDIG; i++) begin
      if (idx_q == IW'(i) && (count_q >> (BCD_W*i)) == '0) begin
        blank = 1'b1;
      end
    end
`endif
  end

  bcd2seg u_bcd2seg (
    .bcd_i (cur_digit),
    .seg_o (glyph)
  );

  assign seg_d = blank ? SEG_BLANK : glyph;
  assign an_d  = ~(NDIG'(1) << idx_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      if (step) begin
        idx_q <= idx_d;
        an_q  <= an_d;
        seg_q <= seg_d;
      end
    end
  end

  assign VALUE = count_q;
  assign OVF   = ovf_q;
  assign AN    = an_q;
  assign SEG   = seg_q;

endmodule

// File: tb/tb_bcd_cnt_disp.sv
// tb/tb_bcd_cnt_disp.sv - randomized self-checking bench for bcd_cnt_disp
module tb_bcd_cnt_disp;

  localparam int NDIG   = 4;
  localparam int CE_DIV = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CE_SCAN = 1'b0;
  logic        BTN_INC = 1'b0;
  logic        BTN_DEC = 1'b0;
  logic        BTN_CLR = 1'b0;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        OVF;
  logic [15:0] VALUE;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: count as a plain integer, scan as tick/step counts.
  int         m_cnt;
  bit         m_ovf;
  int         m_ticks;
  int         m_steps;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] exp_an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg_seq [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  bcd_cnt_disp #(.NDIG(NDIG), .CE_DIV(CE_DIV)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CE_SCAN (CE_SCAN),
    .BTN_INC (BTN_INC),
    .BTN_DEC (BTN_DEC),
    .BTN_CLR (BTN_CLR),
    .SEG     (SEG),
    .AN      (AN),
    .OVF     (OVF),
    .VALUE   (VALUE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int d);
    int r = 1;
    for (int k = 0; k < d; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int d = 0; d < NDIG; d++) r[4*d +: 4] = 4'((v / pow10(d)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] exp_glyph(input int v, input int d);
`ifdef BCD_CNT_DISP_LZB_EN
    if (d > 0 && v < pow10(d)) return 7'h7F;
`endif
    return glyph_tab[(v / pow10(d)) % 10];
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_ovf   = 0;
    m_ticks = 0;
    m_steps = 0;
    m_an    = 4'hF;
    m_seg   = 7'h7F;
  endtask

  task automatic model_step(input bit inc, input bit dec, input bit clr, input bit ce);
    int d;
    if (ce) begin
      m_ticks++;
      if (m_ticks == CE_DIV) begin
        m_ticks = 0;
        d       = m_steps % NDIG;
        m_an    = ~(4'b0001 << d);
        m_seg   = exp_glyph(m_cnt, d);
        m_steps++;
      end
    end
    m_ovf = 0;
    if (clr) begin
      m_cnt = 0;
    end else if (inc && !dec) begin
      if (m_cnt == pow10(NDIG) - 1) begin m_cnt = 0; m_ovf = 1; end
      else m_cnt++;
    end else if (dec && !inc) begin
      if (m_cnt == 0) begin m_cnt = pow10(NDIG) - 1; m_ovf = 1; end
      else m_cnt--;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic cyc(input bit inc, input bit dec, input bit clr, input bit ce);
    BTN_INC = inc;
    BTN_DEC = dec;
    BTN_CLR = clr;
    CE_SCAN = ce;
    @(posedge CLK);
    #1;
    model_step(inc, dec, clr, ce);
    BTN_INC = 1'b0;
    BTN_DEC = 1'b0;
    BTN_CLR = 1'b0;
    CE_SCAN = 1'b0;
    check("value", 32'(VALUE), 32'(to_bcd(m_cnt)));
    check("ovf",   32'(OVF),   32'(m_ovf));
    check("an",    32'(AN),    32'(m_an));
    check("seg",   32'(SEG),   32'(m_seg));
  endtask

  // Reset lands mid-cycle with an INC pending, which must be lost.
  task automatic do_reset(input bit inc_pending);
    BTN_INC = inc_pending;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check("rst_value", 32'(VALUE), 32'h0);
    check("rst_ovf",   32'(OVF),   32'h0);
    check("rst_an",    32'(AN),    32'hF);
    check("rst_seg",   32'(SEG),   32'h7F);
    @(posedge CLK);
    #1;
    RST     = 1'b0;
    BTN_INC = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge CLK);
    #1;
    do_reset(1'b1);

    // Five increments from reset, first one right after release.
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
    check("inc5_value", 32'(VALUE), 32'h0005);

    // Down-wrap from 0 to 9999, then up-wrap back to 0.
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    check("dec_wrap_value", 32'(VALUE), 32'h9999);
    check("dec_wrap_ovf",   32'(OVF),   32'h1);
    cyc(1, 1, 0, 0);
    check("incdec_hold", 32'(VALUE), 32'h9999);
    check("incdec_ovf",  32'(OVF),   32'h0);
    cyc(1, 0, 0, 0);
    check("inc_wrap_value", 32'(VALUE), 32'h0000);
    check("inc_wrap_ovf",   32'(OVF),   32'h1);
    cyc(0, 0, 0, 0);
    check("ovf_one_cycle", 32'(OVF), 32'h0);

    // Clear beats a simultaneous increment and never raises OVF.
    for (int k = 0; k < 120; k++) cyc(1, 0, 0, 0);
    check("cnt_0120", 32'(VALUE), 32'h0120);
    cyc(1, 0, 1, 0);
    check("clr_value", 32'(VALUE), 32'h0000);
    check("clr_ovf",   32'(OVF),   32'h0);

    // Scan order from a fresh reset with count 1234.
    do_reset(1'b0);
    for (int k = 0; k < 1234; k++) cyc(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 1);
      if (k == 0) check("dark_before_step", 32'(AN), 32'hF);
      if (k % 2 == 1) begin
        check("scan_an",  32'(AN),  32'(exp_an_seq[k/2]));
        check("scan_seg", 32'(SEG), 32'(exp_seg_seq[k/2]));
      end
    end

    // Leading-zero cases: count 7, then count 0, full scan each.
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 7; k++) cyc(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);

    // Random traffic with occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      if ($urandom_range(0, 499) == 0) do_reset(1'($urandom_range(0, 1)));
      r = int'($urandom_range(0, 99));
      cyc(r < 40, r >= 30 && r < 65, r >= 97, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
